prism_tx_shifter: RTL and testbench

CPU-to-serial transmit path for the PRISM peripheral, the outbound counterpart of the PRISM-filled 3-byte receive FIFO. The TinyQV core pushes bytes through the peripheral register bus into a small FIFO. A shift engine, stepped by the PRISM OUT_SHIFT strobe, serialises each byte onto a single output bit, MSB- or LSB-first. The block reports FIFO/shifter status to PRISM inputs and raises an interrupt on idle/error.

---
 rtl/prism_tx_shifter.sv | 147 ++++++++++++++
 tb/tb_prism_tx_shifter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_tx_shifter.sv
// PRISM transmit path: a register-bus push FIFO feeding an 8-bit serialiser stepped by shift_req.
// Status/control lives at ADDR_STAT; irq is a registered level on idle or a sticky error.
module prism_tx_shifter #(
    parameter int         DEPTH     = 4,
    parameter logic [5:0] ADDR_DATA = 6'h1C,
    parameter logic [5:0] ADDR_STAT = 6'h1D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic        shift_req,
    input  logic        shift_dir,
    output logic        tx_data,
    output logic        tx_idle,
    output logic        byte_done,
    output logic        fifo_full,
    output logic        fifo_empty,
    output logic        irq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_sr;
    logic [3:0]       r_bcnt;
    logic             r_overflow;
    logic             r_underrun;
    logic             r_irq_en;
    logic             r_byte_done;
    logic             r_irq;

    logic w_write, w_wr_data, w_wr_stat, w_flush;
    logic w_full, w_empty, w_busy, w_tx_idle;
    logic w_load, w_shift, w_last_shift, w_reload, w_pop, w_push;
    logic w_overflow_evt, w_underrun_evt;
    logic w_unused;

    assign w_write   = (data_write_n != 2'b11);
    assign w_wr_data = w_write && (address == ADDR_DATA);
    assign w_wr_stat = w_write && (address == ADDR_STAT);
    assign w_flush   = w_wr_stat && data_in[15];

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_busy    = (r_bcnt != 4'd0);
    assign w_tx_idle = !w_busy && w_empty;

    // A shift that empties the shifter pops the next byte in the same cycle, so the
    // serial stream has no gap and the strobe never sees an empty shifter.
    assign w_load       = !w_busy && !w_empty;
    assign w_shift      = w_busy && shift_req;
    assign w_last_shift = w_shift && (r_bcnt == 4'd1);
    assign w_reload     = w_last_shift && !w_empty;
    assign w_pop        = w_load || w_reload;
    assign w_push       = w_wr_data && (!w_full || w_pop);

    assign w_overflow_evt = w_wr_data && w_full && !w_pop;
    assign w_underrun_evt = shift_req && !w_busy;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_sr        <= 8'h00;
            r_bcnt      <= 4'd0;
            r_overflow  <= 1'b0;
            r_underrun  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_byte_done <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_byte_done <= w_last_shift && !w_flush;
            r_irq       <= r_irq_en && (w_tx_idle || r_overflow || r_underrun);
            r_overflow  <= (r_overflow && !(w_wr_stat && data_in[9])) || w_overflow_evt;
            r_underrun  <= (r_underrun && !(w_wr_stat && data_in[10])) || w_underrun_evt;
            if (w_wr_stat) begin
                r_irq_en <= data_in[8];
            end

            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_sr     <= 8'h00;
                r_bcnt   <= 4'd0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: ;
                endcase

                if (w_pop) begin
                    r_sr   <= r_mem[r_rd_ptr];
                    r_bcnt <= 4'd8;
                end else if (w_shift) begin
                    r_sr   <= shift_dir ? {1'b0, r_sr[7:1]} : {r_sr[6:0], 1'b0};
                    r_bcnt <= r_bcnt - 4'd1;
                end
            end
        end
    end

    // NOTE: the data array has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= data_in[7:0];
        end
    end

    // NOTE: data_out gets its default first so no path leaves it unassigned (no latch).
    always_comb begin
        data_out = 32'h0;
        if (address == ADDR_STAT) begin
            data_out = {21'h0, r_underrun, r_overflow, r_irq_en, 4'(r_count),
                        w_busy, 1'b0, w_full, w_empty};
        end
    end

    assign data_ready = 1'b1;
    assign tx_data    = w_busy ? (shift_dir ? r_sr[0] : r_sr[7]) : 1'b1;
    assign tx_idle    = w_tx_idle;
    assign byte_done  = r_byte_done;
    assign fifo_full  = w_full;
    assign fifo_empty = w_empty;
    assign irq        = r_irq;

    assign w_unused = ^{data_read_n, data_in[31:16], data_in[14:11]};

endmodule

// File: tb/tb_prism_tx_shifter.sv
// Randomised self-checking bench for prism_tx_shifter against a queue-based transmit model.
module tb_prism_tx_shifter;

    localparam int         DEPTH  = 4;
    localparam logic [5:0] A_DATA = 6'h1C;
    localparam logic [5:0] A_STAT = 6'h1D;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        shift_req;
    logic        shift_dir;
    logic        tx_data;
    logic        tx_idle;
    logic        byte_done;
    logic        fifo_full;
    logic        fifo_empty;
    logic        irq;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: queued bytes, the byte on the wire and how many of its bits are still to go.
    logic [7:0] m_q[$];
    int         m_bits;
    logic [7:0] m_cur;
    bit         m_ovf, m_unr, m_ien, m_bdone, m_irq;

    prism_tx_shifter #(.DEPTH(DEPTH), .ADDR_DATA(A_DATA), .ADDR_STAT(A_STAT)) dut (
        .clk(clk), .rst(rst), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .shift_req(shift_req), .shift_dir(shift_dir),
        .tx_data(tx_data), .tx_idle(tx_idle), .byte_done(byte_done),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic exp_tx();
        if (m_bits == 0) return 1'b1;
        return shift_dir ? m_cur[8 - m_bits] : m_cur[m_bits - 1];
    endfunction

    function automatic logic exp_idle();
        return (m_bits == 0) && (m_q.size() == 0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [5:0] a);
        logic [31:0] s;
        s = 32'h0;
        if (a == A_STAT) begin
            s[10]  = m_unr;
            s[9]   = m_ovf;
            s[8]   = m_ien;
            s[7:4] = 4'(m_q.size());
            s[3]   = (m_bits != 0);
            s[1]   = (m_q.size() == DEPTH);
            s[0]   = (m_q.size() == 0);
        end
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_bits  = 0;
        m_cur   = 8'h00;
        m_ovf   = 0;
        m_unr   = 0;
        m_ien   = 0;
        m_bdone = 0;
        m_irq   = 0;
    endtask

    task automatic drive(input logic [5:0] a, input logic [31:0] d, input logic wr, input logic sreq);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = wr ? 2'b00 : 2'b11;
        data_read_n  = wr ? 2'b11 : 2'b00;
        shift_req    = sreq;
        #1;
    endtask

    // Advance the model by the cycle currently being driven, then let the clock edge happen.
    task automatic tick();
        bit wr, wd, ws, fl, full_b, popped, n_bd, n_irq, unr_e;
        if (rst) begin
            model_reset();
        end else begin
            wr     = (data_write_n != 2'b11);
            wd     = wr && (address == A_DATA);
            ws     = wr && (address == A_STAT);
            fl     = ws && data_in[15];
            full_b = (m_q.size() == DEPTH);
            popped = 0;
            n_bd   = shift_req && (m_bits == 1) && !fl;
            n_irq  = m_ien && (exp_idle() || m_ovf || m_unr);
            unr_e  = shift_req && (m_bits == 0);
            if (ws) begin
                if (data_in[9])  m_ovf = 0;
                if (data_in[10]) m_unr = 0;
                m_ien = data_in[8];
            end
            if (unr_e) m_unr = 1;
            if (fl) begin
                m_q.delete();
                m_bits = 0;
                m_cur  = 8'h00;
            end else begin
                if (m_bits == 0) begin
                    if (m_q.size() > 0) begin
                        m_cur = m_q.pop_front(); m_bits = 8; popped = 1;
                    end
                end else if (shift_req) begin
                    m_bits--;
                    if (m_bits == 0 && m_q.size() > 0) begin
                        m_cur = m_q.pop_front(); m_bits = 8; popped = 1;
                    end
                end
                if (wd) begin
                    if (!full_b || popped) m_q.push_back(data_in[7:0]);
                    else m_ovf = 1;
                end
            end
            m_bdone = n_bd;
            m_irq   = n_irq;
        end
        @(posedge clk);
    endtask

    task automatic cycle(input logic [5:0] a, input logic [31:0] d, input logic wr, input logic sreq);
        drive(a, d, wr, sreq);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(A_STAT, 32'h0, 1'b0, 1'b0);
        cycle(A_STAT, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status got %h want %h", data_out, 32'h1); end
        n_vec++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_data); end
        n_vec++; if (tx_idle !== 1'b1 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags idle/empty/full got %b%b%b want 110", tx_idle, fifo_empty, fifo_full);
        end
        n_vec++; if (irq !== 1'b0 || byte_done !== 1'b0) begin n_fail++; $display("FAIL reset_irq_bd got %b%b want 00", irq, byte_done); end
        n_vec++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL data_ready got %b want 1", data_ready); end
        tick();
    endtask

    task automatic test_msb_byte();
        int pulses = 0;
        logic [7:0] pat = 8'hA5;
        shift_dir = 1'b0;
        cycle(A_DATA, 32'h0000_00A5, 1'b1, 1'b0);
        cycle(A_STAT, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 3; j++) begin
                drive(A_STAT, 32'h0, 1'b0, j == 0);
                if (j == 0) begin
                    n_vec++; if (tx_data !== pat[7 - i]) begin n_fail++; $display("FAIL msb_seq bit%0d got %b want %b", i, tx_data, pat[7 - i]); end
                end
                n_vec++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL msb_tx bit%0d got %b want %b", i, tx_data, exp_tx()); end
                n_vec++; if (byte_done !== m_bdone) begin n_fail++; $display("FAIL msb_bdone bit%0d got %b want %b", i, byte_done, m_bdone); end
                if (byte_done === 1'b1) pulses++;
                tick();
            end
        end
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        if (byte_done === 1'b1) pulses++;
        n_vec++; if (pulses != 1) begin n_fail++; $display("FAIL msb_pulses got %0d want 1", pulses); end
        n_vec++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL msb_idle got %b want 1", tx_idle); end
        n_vec++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL msb_status got %h want %h", data_out, 32'h1); end
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        logic [15:0] pat = 16'h8001;
        shift_dir = 1'b1;
        cycle(A_DATA, 32'h0000_0001, 1'b1, 1'b0);
        cycle(A_DATA, 32'h0000_0080, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) begin
            drive(A_STAT, 32'h0, 1'b0, i < 16);
            if (i < 16) begin
                n_vec++; if (tx_data !== pat[i]) begin n_fail++; $display("FAIL b2b_seq bit%0d got %b want %b", i, tx_data, pat[i]); end
                n_vec++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL b2b_tx bit%0d got %b want %b", i, tx_data, exp_tx()); end
            end
            n_vec++; if (byte_done !== m_bdone) begin n_fail++; $display("FAIL b2b_bdone cyc%0d got %b want %b", i, byte_done, m_bdone); end
            if (byte_done === 1'b1) pulses++;
            tick();
        end
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (pulses != 2) begin n_fail++; $display("FAIL b2b_pulses got %0d want 2", pulses); end
        n_vec++; if (data_out[10] !== 1'b0) begin n_fail++; $display("FAIL b2b_underrun got %b want 0", data_out[10]); end
        n_vec++; if (data_out !== exp_read(A_STAT)) begin n_fail++; $display("FAIL b2b_status got %h want %h", data_out, exp_read(A_STAT)); end
        tick();
    endtask

    task automatic test_overflow();
        shift_dir = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cycle(A_DATA, 32'($urandom_range(0, 255)), 1'b1, 1'b0);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", fifo_full); end
        n_vec++; if (data_out !== 32'h0000_024A) begin n_fail++; $display("FAIL ovf_status got %h want %h", data_out, 32'h24A); end
        n_vec++; if (data_out !== exp_read(A_STAT)) begin n_fail++; $display("FAIL ovf_model got %h want %h", data_out, exp_read(A_STAT)); end
        tick();
        cycle(A_STAT, 32'h0000_0200, 1'b1, 1'b0);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_004A) begin n_fail++; $display("FAIL ovf_clear got %h want %h", data_out, 32'h4A); end
        tick();
        cycle(A_STAT, 32'h0000_8000, 1'b1, 1'b0);
    endtask

    task automatic test_underrun();
        cycle(A_STAT, 32'h0000_0100, 1'b1, 1'b0);
        cycle(A_STAT, 32'h0, 1'b0, 1'b0);
        cycle(A_STAT, 32'h0, 1'b0, 1'b1);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_0501) begin n_fail++; $display("FAIL unr_status got %h want %h", data_out, 32'h501); end
        n_vec++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL unr_tx got %b want 1", tx_data); end
        n_vec++; if (irq !== m_irq) begin n_fail++; $display("FAIL unr_irq got %b want %b", irq, m_irq); end
        tick();
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (irq !== 1'b1) begin n_fail++; $display("FAIL unr_irq_late got %b want 1", irq); end
        tick();
        cycle(A_STAT, 32'h0000_0400, 1'b1, 1'b0);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL unr_clear got %h want %h", data_out, 32'h1); end
        tick();
    endtask

    task automatic test_flush();
        shift_dir = 1'b0;
        for (int i = 0; i < 3; i++) cycle(A_DATA, 32'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(A_STAT, 32'h0, 1'b0, 1'b1);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== exp_read(A_STAT)) begin n_fail++; $display("FAIL flush_pre got %h want %h", data_out, exp_read(A_STAT)); end
        tick();
        cycle(A_STAT, 32'h0000_8000, 1'b1, 1'b0);
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL flush_status got %h want %h", data_out, 32'h1); end
        n_vec++; if (tx_data !== 1'b1) begin n_fail++; $display("FAIL flush_tx got %b want 1", tx_data); end
        tick();
    endtask

    task automatic test_reset_mid_byte();
        shift_dir = 1'b0;
        cycle(A_STAT, 32'h0000_0100, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(A_DATA, 32'($urandom_range(0, 255)), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(A_STAT, 32'h0, 1'b0, 1'b1);
        rst = 1'b1;
        cycle(A_STAT, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(A_STAT, 32'h0, 1'b0, 1'b0);
        n_vec++; if (data_out !== 32'h0000_0001) begin n_fail++; $display("FAIL rstmid_status got %h want %h", data_out, 32'h1); end
        n_vec++; if (tx_data !== 1'b1 || fifo_empty !== 1'b1 || irq !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_flags tx/empty/irq got %b%b%b want 110", tx_data, fifo_empty, irq);
        end
        tick();
    endtask

    task automatic test_random(input logic dir, input int n);
        logic [5:0]  a;
        logic [31:0] d;
        logic        w;
        int          r;
        cycle(A_STAT, 32'h0000_8000, 1'b1, 1'b0);
        shift_dir = dir;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom;
            w = 1'b0;
            if (r < 35) begin
                a = A_DATA; w = 1'b1;
            end else if (r < 42) begin
                a = A_STAT; w = 1'b1;
                d = d & 32'h0000_0700;
                if ($urandom_range(0, 24) == 0) d[15] = 1'b1;
            end else begin
                case ($urandom_range(0, 2))
                    0:       a = A_DATA;
                    1:       a = A_STAT;
                    default: a = 6'($urandom);
                endcase
            end
            drive(a, d, w, $urandom_range(0, 2) == 0);
            n_vec++; if (data_out !== exp_read(a)) begin n_fail++; $display("FAIL rnd_read cyc%0d addr %h got %h want %h", i, a, data_out, exp_read(a)); end
            n_vec++; if (tx_data !== exp_tx()) begin n_fail++; $display("FAIL rnd_tx cyc%0d got %b want %b", i, tx_data, exp_tx()); end
            n_vec++; if (tx_idle !== exp_idle()) begin n_fail++; $display("FAIL rnd_idle cyc%0d got %b want %b", i, tx_idle, exp_idle()); end
            n_vec++; if (fifo_full !== (m_q.size() == DEPTH) || fifo_empty !== (m_q.size() == 0)) begin
                n_fail++; $display("FAIL rnd_fifo cyc%0d full/empty got %b%b size %0d", i, fifo_full, fifo_empty, m_q.size());
            end
            n_vec++; if (byte_done !== m_bdone) begin n_fail++; $display("FAIL rnd_bdone cyc%0d got %b want %b", i, byte_done, m_bdone); end
            n_vec++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd_irq cyc%0d got %b want %b", i, irq, m_irq); end
            tick();
        end
        cycle(A_STAT, 32'h0000_8000, 1'b1, 1'b0);
    endtask

    initial begin
        rst          = 1'b1;
        address      = A_STAT;
        data_in      = 32'h0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        shift_req    = 1'b0;
        shift_dir    = 1'b0;
        model_reset();
        test_reset();
        test_msb_byte();
        test_back_to_back();
        test_overflow();
        test_underrun();
        test_flush();
        test_reset_mid_byte();
        test_random(1'b0, 600);
        test_random(1'b1, 600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
